// File: rtl/riscv_pkg.sv
// riscv_pkg: shared datapath constants and the writeback result-select encoding.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int REGW  = $clog2(NREGS);

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_MEM  = 2'b01,
        RES_PC4  = 2'b10,
        RES_RSVD = 2'b11
    } resultsrc_t;

    localparam logic [REGW-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_result_mux.sv
// wb_result_mux: combinational 4:1 writeback result select, shared with the forwarding path.
module wb_result_mux #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [1:0]      resultsrc,
    input  logic [XLEN-1:0] aluresult,
    input  logic [XLEN-1:0] readdata,
    input  logic [XLEN-1:0] pcplus4,
    output logic [XLEN-1:0] result
);
    import riscv_pkg::*;

    logic [XLEN-1:0] result_s;

    // Select the W-stage value; the reserved encoding yields zero.
    always_comb begin
        result_s = {XLEN{1'b0}};
        case (resultsrc_t'(resultsrc))
            RES_ALU:  result_s = aluresult;
            RES_MEM:  result_s = readdata;
            RES_PC4:  result_s = pcplus4;
            RES_RSVD: result_s = {XLEN{1'b0}};
            default:  result_s = {XLEN{1'b0}};
        endcase
    end

    assign result = result_s;

endmodule

// File: rtl/writeback_regfile.sv
// writeback_regfile: W-stage result select, x1..x31 register file and committed-write counter.
// Build option: define WB_BYPASS_EN for write-through bypass of resultW onto the read ports.
module writeback_regfile #(
    parameter int  XLEN  = riscv_pkg::XLEN,
    parameter int  NREGS = riscv_pkg::NREGS,
    parameter int  CNTW  = 32,
    localparam int REGW  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            regwriteW,
    input  logic [1:0]      resultsrcW,
    input  logic [XLEN-1:0] aluresultW,
    input  logic [XLEN-1:0] readdataW,
    input  logic [REGW-1:0] rdW,
    input  logic [XLEN-1:0] pcplus4W,
    input  logic [REGW-1:0] rs1D,
    input  logic [REGW-1:0] rs2D,
    output logic [XLEN-1:0] rd1D,
    output logic [XLEN-1:0] rd2D,
    output logic [XLEN-1:0] resultW,
    output logic [CNTW-1:0] wrcount
);
    import riscv_pkg::*;

    // x0 has no storage; index 0 is decoded to a constant zero on read.
    logic [XLEN-1:0] regs_r [1:NREGS-1];
    logic [CNTW-1:0] wrcount_r;
    logic [XLEN-1:0] result_s;
    logic            commit_s;
    logic [XLEN-1:0] rd1_s;
    logic [XLEN-1:0] rd2_s;

    wb_result_mux #(
        .XLEN (XLEN)
    ) u_result_mux (
        .resultsrc (resultsrcW),
        .aluresult (aluresultW),
        .readdata  (readdataW),
        .pcplus4   (pcplus4W),
        .result    (result_s)
    );

    // Reset takes priority, so a write presented during reset is dropped.
    assign commit_s = regwriteW && (rdW != REG_ZERO) && !reset;

    // Register array and counter update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
            wrcount_r <= {CNTW{1'b0}};
        end else if (commit_s) begin
            regs_r[rdW] <= result_s;
            wrcount_r   <= wrcount_r + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            wrcount_r <= wrcount_r;
        end
    end

`ifdef WB_BYPASS_EN
    // Read port 1 with same-cycle write-through from the committing result.
    always_comb begin
        rd1_s = {XLEN{1'b0}};
        if (commit_s && (rdW == rs1D)) begin
            rd1_s = result_s;
        end else if (rs1D == REG_ZERO) begin
            rd1_s = {XLEN{1'b0}};
        end else begin
            rd1_s = regs_r[rs1D];
        end
    end

    // Read port 2 with same-cycle write-through from the committing result.
    always_comb begin
        rd2_s = {XLEN{1'b0}};
        if (commit_s && (rdW == rs2D)) begin
            rd2_s = result_s;
        end else if (rs2D == REG_ZERO) begin
            rd2_s = {XLEN{1'b0}};
        end else begin
            rd2_s = regs_r[rs2D];
        end
    end
`else
    // Read port 1: array contents only; new data appears the cycle after the write edge.
    always_comb begin
        rd1_s = {XLEN{1'b0}};
        if (rs1D == REG_ZERO) begin
            rd1_s = {XLEN{1'b0}};
        end else begin
            rd1_s = regs_r[rs1D];
        end
    end

    // Read port 2: array contents only; new data appears the cycle after the write edge.
    always_comb begin
        rd2_s = {XLEN{1'b0}};
        if (rs2D == REG_ZERO) begin
            rd2_s = {XLEN{1'b0}};
        end else begin
            rd2_s = regs_r[rs2D];
        end
    end
`endif

    assign rd1D    = rd1_s;
    assign rd2D    = rd2_s;
    assign resultW = result_s;
    assign wrcount = wrcount_r;

endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: table-driven plus scoreboarded random checks of writeback_regfile,
// with a second narrow-counter instance to exercise counter wrap.
module tb_writeback_regfile;

    logic        clk;
    logic        reset;
    logic        regwriteW;
    logic [1:0]  resultsrcW;
    logic [31:0] aluresultW;
    logic [31:0] readdataW;
    logic [4:0]  rdW;
    logic [31:0] pcplus4W;
    logic [4:0]  rs1D;
    logic [4:0]  rs2D;
    logic [31:0] rd1D, rd2D, resultW, wrcount;
    logic [31:0] s_rd1D, s_rd2D, s_resultW;
    logic [3:0]  s_wrcount;

    writeback_regfile dut (
        .clk(clk), .reset(reset), .regwriteW(regwriteW), .resultsrcW(resultsrcW),
        .aluresultW(aluresultW), .readdataW(readdataW), .rdW(rdW), .pcplus4W(pcplus4W),
        .rs1D(rs1D), .rs2D(rs2D), .rd1D(rd1D), .rd2D(rd2D), .resultW(resultW),
        .wrcount(wrcount)
    );

    writeback_regfile #(.CNTW(4)) u_small (
        .clk(clk), .reset(reset), .regwriteW(regwriteW), .resultsrcW(resultsrcW),
        .aluresultW(aluresultW), .readdataW(readdataW), .rdW(rdW), .pcplus4W(pcplus4W),
        .rs1D(rs1D), .rs2D(rs2D), .rd1D(s_rd1D), .rd2D(s_rd2D), .resultW(s_resultW),
        .wrcount(s_wrcount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] result;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] cnt;
        logic [3:0]  cnt_s;
    } exp_t;

    typedef struct {
        logic        we;
        logic [1:0]  src;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] exp_result;
    } vec_t;

    exp_t        sb_q[$];
    logic [31:0] mdl_regs [32];
    logic [31:0] mdl_cnt;
    int          n_assert;
    int          n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_result(input logic [1:0] src, input logic [31:0] alu,
                                                 input logic [31:0] rdata, input logic [31:0] pc4);
        case (src)
            2'b00:   return alu;
            2'b01:   return rdata;
            2'b10:   return pc4;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] rs, input logic rst,
                                               input logic we, input logic [4:0] rd,
                                               input logic [31:0] res);
`ifdef WB_BYPASS_EN
        if (!rst && we && rd != 5'd0 && rd == rs) return res;
`endif
        if (rs == 5'd0) return 32'h0;
        return mdl_regs[rs];
    endfunction

    // Apply inputs (just after a rising edge) and queue the expected outputs for this cycle.
    task automatic drive(input logic rst, input logic we, input logic [1:0] src,
                         input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pc4,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        exp_t e;
        reset = rst; regwriteW = we; resultsrcW = src; aluresultW = alu;
        readdataW = rdata; pcplus4W = pc4; rdW = rd; rs1D = rs1; rs2D = rs2;
        e.result = model_result(src, alu, rdata, pc4);
        e.rd1    = model_read(rs1, rst, we, rd, e.result);
        e.rd2    = model_read(rs2, rst, we, rd, e.result);
        e.cnt    = mdl_cnt;
        e.cnt_s  = mdl_cnt[3:0];
        sb_q.push_back(e);
    endtask

    // Compare on the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        exp_t e;
        logic [31:0] r;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("resultW", resultW, e.result);
            check("rd1D", rd1D, e.rd1);
            check("rd2D", rd2D, e.rd2);
            check("wrcount", wrcount, e.cnt);
            check("wrcount_small", {28'd0, s_wrcount}, {28'd0, e.cnt_s});
        end
        r = model_result(resultsrcW, aluresultW, readdataW, pcplus4W);
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) mdl_regs[i] = 32'h0;
            mdl_cnt = 32'h0;
        end else if (regwriteW && rdW != 5'd0) begin
            mdl_regs[rdW] = r;
            mdl_cnt = mdl_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic idle(input logic [4:0] rs1, input logic [4:0] rs2);
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, rs1, rs2);
        #1;
    endtask

    vec_t tv [8];

    initial begin
        n_assert = 0;
        n_fail   = 0;
        mdl_cnt  = 32'h0;
        for (int i = 0; i < 32; i++) mdl_regs[i] = 32'h0;
        reset = 1'b1; regwriteW = 1'b0; resultsrcW = 2'b00; aluresultW = 32'h0;
        readdataW = 32'h0; pcplus4W = 32'h0; rdW = 5'd0; rs1D = 5'd0; rs2D = 5'd0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state: every register reads zero, counter zero.
        for (int i = 0; i < 32; i += 2) begin
            idle(5'(i), 5'(i + 1));
            check("reset_rd1", rd1D, 32'h0);
            check("reset_rd2", rd2D, 32'h0);
            check("reset_wrcount", wrcount, 32'h0);
            cycle();
        end

        //        we  src    alu           rdata         pc4           rd  rs1 rs2 result
        tv[0] = '{1'b1, 2'b00, 32'hDEADBEEF, 32'h0,        32'h0,        5'd5, 5'd5, 5'd0, 32'hDEADBEEF};
        tv[1] = '{1'b0, 2'b00, 32'h0,        32'h0,        32'h0,        5'd0, 5'd5, 5'd5, 32'h0};
        tv[2] = '{1'b1, 2'b00, 32'h1234,     32'h0,        32'h0,        5'd0, 5'd0, 5'd5, 32'h1234};
        tv[3] = '{1'b1, 2'b01, 32'h0,        32'hA5A5A5A5, 32'h0,        5'd7, 5'd7, 5'd7, 32'hA5A5A5A5};
        tv[4] = '{1'b1, 2'b10, 32'h0,        32'h0,        32'h00000104, 5'd7, 5'd7, 5'd7, 32'h00000104};
        tv[5] = '{1'b0, 2'b11, 32'hFFFF,     32'hFFFF,     32'hFFFF,     5'd0, 5'd7, 5'd7, 32'h0};
        tv[6] = '{1'b1, 2'b11, 32'h77,       32'h88,       32'h99,       5'd9, 5'd9, 5'd7, 32'h0};
        tv[7] = '{1'b0, 2'b00, 32'h0,        32'h0,        32'h0,        5'd0, 5'd9, 5'd9, 32'h0};
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, tv[i].we, tv[i].src, tv[i].alu, tv[i].rdata, tv[i].pc4,
                  tv[i].rd, tv[i].rs1, tv[i].rs2);
            #1;
            check("tbl_resultW", resultW, tv[i].exp_result);
            if (i == 1) check("x5_after_write", rd1D, 32'hDEADBEEF);
            if (i == 1) check("wrcount_one", wrcount, 32'd1);
            if (i == 3) check("x0_write_dropped", wrcount, 32'd1);
            cycle();
        end

        // Back-to-back x7 writes leave the later value; x9 took the reserved-select zero.
        idle(5'd7, 5'd7);
        check("x7_rs1", rd1D, 32'h00000104);
        check("x7_rs2", rd2D, 32'h00000104);
        check("wrcount_four", wrcount, 32'd4);
        cycle();
        idle(5'd9, 5'd0);
        check("x9_zero", rd1D, 32'h0);
        cycle();

        // Write during reset is discarded; reset-cycle reads still show old contents.
        drive(1'b0, 1'b1, 2'b00, 32'h11, 32'h0, 32'h0, 5'd3, 5'd0, 5'd0);
        cycle();
        drive(1'b1, 1'b1, 2'b00, 32'h55, 32'h0, 32'h0, 5'd3, 5'd3, 5'd7);
        #1;
        check("reset_cycle_old_x3", rd1D, 32'h11);
        cycle();
        idle(5'd3, 5'd7);
        check("x3_after_reset", rd1D, 32'h0);
        check("x7_after_reset", rd2D, 32'h0);
        check("wrcount_after_reset", wrcount, 32'h0);
        cycle();

        // Random traffic against the model, with occasional resets.
        for (int i = 0; i < 60; i++) begin
            drive(($urandom_range(19) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(1)),
                  2'($urandom_range(3)), $urandom, $urandom, $urandom,
                  5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)));
            cycle();
        end

        // Counter wrap on the 4-bit instance.
        drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        cycle();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 2'b00, 32'(i + 100), 32'h0, 32'h0, 5'((i % 31) + 1), 5'd1, 5'd2);
            cycle();
        end
        idle(5'd1, 5'd16);
        check("small_wrap_zero", {28'd0, s_wrcount}, 32'd0);
        check("wide_sixteen", wrcount, 32'd16);
        check("x16_value", rd2D, 32'd115);
        cycle();
        drive(1'b0, 1'b1, 2'b00, 32'h1, 32'h0, 32'h0, 5'd20, 5'd20, 5'd0);
        cycle();
        idle(5'd20, 5'd0);
        check("small_after_wrap", {28'd0, s_wrcount}, 32'd1);
        cycle();

        if (sb_q.size() != 0) check("scoreboard_leftover", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
